// File: rtl/typedef_unpack.sv
// typedef_unpack: takes one packed record of three FIELD_W-bit fields and
// streams the fields out most-significant first under valid/ready.
// Build option: define TYPEDEF_UNPACK_CHKSUM_EN to add the end-of-record field
// sum (SUM state + accumulator); otherwise sum_valid/sum_data are tied to 0.
// All outputs are registered; the *_next values are computed combinationally.
module typedef_unpack #(
  parameter int FIELD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*FIELD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FIELD_W-1:0]   out_data,
  output logic [1:0]           out_idx,
  output logic                 out_last,
  output logic                 sum_valid,
  output logic [FIELD_W+1:0]   sum_data
);

  localparam int REC_W = 3 * FIELD_W;

`ifdef TYPEDEF_UNPACK_CHKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, SUM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1} state_t;
`endif

  state_t state, state_next;

  // Remaining fields of the record, next field to emit in the top lane.
  logic [REC_W-1:0]   shreg, shreg_next;
  logic               in_ready_next, out_valid_next, out_last_next;
  logic [FIELD_W-1:0] out_data_next;
  logic [1:0]         out_idx_next;
  logic               accept, last_beat;

  assign accept    = (state == IDLE) && in_valid && in_ready;
  assign last_beat = (state == EMIT) && out_ready && (out_idx == 2'd0);

`ifdef TYPEDEF_UNPACK_CHKSUM_EN
  logic [FIELD_W+1:0] acc, acc_next;
  logic               sum_valid_next;
  logic [FIELD_W+1:0] sum_data_next;
`endif

  // State and registered outputs; reset drops any record in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
`ifdef TYPEDEF_UNPACK_CHKSUM_EN
      acc       <= '0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
`endif
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      out_idx   <= out_idx_next;
      out_last  <= out_last_next;
`ifdef TYPEDEF_UNPACK_CHKSUM_EN
      acc       <= acc_next;
      sum_valid <= sum_valid_next;
      sum_data  <= sum_data_next;
`endif
    end
  end

  // Next-state: accept in IDLE, leave EMIT when the field-0 beat is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = EMIT;
`ifdef TYPEDEF_UNPACK_CHKSUM_EN
      EMIT: if (last_beat) state_next = SUM;
      SUM:  state_next = IDLE;
`else
      EMIT: if (last_beat) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values; everything holds unless a transfer happens.
  always_comb begin
    shreg_next     = shreg;
    in_ready_next  = in_ready;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    out_idx_next   = out_idx;
    out_last_next  = out_last;
`ifdef TYPEDEF_UNPACK_CHKSUM_EN
    acc_next       = acc;
    sum_valid_next = 1'b0;
    sum_data_next  = sum_data;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          in_ready_next  = 1'b0;
          out_valid_next = 1'b1;
          out_data_next  = in_data[REC_W-1 -: FIELD_W];
          out_idx_next   = 2'd2;
          out_last_next  = 1'b0;
          shreg_next     = in_data << FIELD_W;
`ifdef TYPEDEF_UNPACK_CHKSUM_EN
          acc_next       = '0;
`endif
        end else begin
          // First IDLE cycle after reset or a record raises in_ready.
          in_ready_next = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
`ifdef TYPEDEF_UNPACK_CHKSUM_EN
          acc_next = acc + {2'b00, out_data};
`endif
          if (out_idx != 2'd0) begin
            out_data_next = shreg[REC_W-1 -: FIELD_W];
            shreg_next    = shreg << FIELD_W;
            out_idx_next  = out_idx - 2'd1;
            out_last_next = (out_idx == 2'd1);
          end else begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
`ifdef TYPEDEF_UNPACK_CHKSUM_EN
            sum_valid_next = 1'b1;
            sum_data_next  = acc + {2'b00, out_data};
`else
            in_ready_next  = 1'b1;
`endif
          end
        end
      end
`ifdef TYPEDEF_UNPACK_CHKSUM_EN
      SUM: in_ready_next = 1'b1;
`endif
      default: ;
    endcase
  end

`ifndef TYPEDEF_UNPACK_CHKSUM_EN
  assign sum_valid = 1'b0;
  assign sum_data  = '0;
`endif

endmodule
